pixel_sram_responder: RTL and testbench

Synthesizable SRAM-side responder for the pixel controller's memory port: it accepts the controller's `address` / `read_enable` / `write_enable` / `w_data` requests and returns 24-bit pixels on `r_data` after a fixed, pipelined read latency. It replaces the behavioural off-chip SRAM model in on-chip configurations and in lint/synthesis flows. A small memory of 2^DEPTH_BITS pixels is implemented, along with a whole-memory clear sequence that mirrors the model's `mem_clr`.

---
 rtl/pixel_sram_pkg.sv | 19 +
 rtl/pixel_read_pipe.sv | 46 ++++
 rtl/pixel_sram_responder.sv | 129 ++++++++++++
 tb/tb_pixel_sram_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_sram_pkg.sv
// Shared types and default widths for the pixel controller memory port.
// Used by pixel_sram_responder and the pixel controller.
package pixel_sram_pkg;

    localparam int PIX_ADDR_BITS = 16;
    localparam int PIX_DATA_BITS = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } resp_state_t;

endpackage

// File: rtl/pixel_read_pipe.sv
// Fixed-latency {valid, data} shift register for read returns.
// Data is forced to zero on every stage that carries no valid read.
module pixel_read_pipe #(
    parameter int LATENCY = 2,
    parameter int WIDTH   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY-1:0][WIDTH-1:0] dat_q;
    logic [WIDTH-1:0]              in_dat;

    assign in_dat = in_valid ? in_data : '0;

    if (LATENCY == 1) begin : g_one
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                dat_q[0] <= in_dat;
            end
        end
    end else begin : g_many
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= {vld_q[LATENCY-2:0], in_valid};
                dat_q <= {dat_q[LATENCY-2:0], in_dat};
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/pixel_sram_responder.sv
// On-chip SRAM responder for the pixel controller memory port.
// Define PIXEL_SRAM_RESP_STATS_EN to add saturating request counters.
module pixel_sram_responder
    import pixel_sram_pkg::*;
#(
    parameter int ADDR_BITS    = PIX_ADDR_BITS,
    parameter int DATA_BITS    = PIX_DATA_BITS,
    parameter int DEPTH_BITS   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 read_enable,
    input  logic                 write_enable,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 clear,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 r_valid,
    output logic                 addr_err,
`ifdef PIXEL_SRAM_RESP_STATS_EN
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count,
    output logic [15:0]          err_count,
`endif
    output logic                 busy
);

    resp_state_t           state;
    resp_state_t           state_nx;
    logic [DEPTH_BITS-1:0] clr_cnt;
    logic                  idle;
    logic                  in_range;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  err_nx;
    logic                  mem_we;
    logic [DEPTH_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0]  mem_wdata;
    logic [DATA_BITS-1:0]  rd_word;
    logic [DATA_BITS-1:0]  mem [2**DEPTH_BITS];

    // rst gates requests so nothing lands in the array while reset is held
    assign idle     = (state == IDLE) && !rst;
    assign in_range = (address >> DEPTH_BITS) == '0;
    assign rd_acc   = idle && read_enable && !write_enable && in_range;
    assign wr_acc   = idle && write_enable && in_range;
    assign err_nx   = idle && (read_enable || write_enable) && !in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (clear) state_nx = CLEAR;
            CLEAR:   if (clr_cnt == '1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = address[DEPTH_BITS-1:0];
        mem_wdata = w_data;
        unique case (1'b1)
            (state == CLEAR): begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_cnt;
                mem_wdata = '0;
            end
            wr_acc:  mem_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt  <= '0;
            addr_err <= 1'b0;
        end else begin
            clr_cnt  <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            addr_err <= err_nx;
        end
    end

    // Array deliberately has no reset; contents persist across rst
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign rd_word = mem[address[DEPTH_BITS-1:0]];

    pixel_read_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (DATA_BITS)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (r_valid),
        .out_data  (r_data)
    );

`ifdef PIXEL_SRAM_RESP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else begin
            if (rd_acc && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (wr_acc && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (err_nx && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_sram_responder.sv
// Scoreboard bench for pixel_sram_responder (default parameters).
// Expected reads/errors are queued at drive time and checked at negedge.
module tb_pixel_sram_responder;
    import pixel_sram_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic        read_enable;
    logic        write_enable;
    logic [23:0] w_data;
    logic        clear;
    logic [23:0] r_data;
    logic        r_valid;
    logic        addr_err;
    logic        busy;
`ifdef PIXEL_SRAM_RESP_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] err_count;
`endif

    pixel_sram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .w_data       (w_data),
        .clear        (clear),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .addr_err     (addr_err),
`ifdef PIXEL_SRAM_RESP_STATS_EN
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .err_count    (err_count),
`endif
        .busy         (busy)
    );

    typedef struct {
        int          cyc;
        logic [23:0] data;
    } rd_exp_t;

    rd_exp_t     vq[$];
    int          eq[$];
    logic [23:0] mdl [256];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic        mv;
    logic        me;
    int          n;
    pixel_t      px;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic re, input logic we,
                        input logic [15:0] a, input logic [23:0] d);
        int      k;
        rd_exp_t e;
        k = cyc + 1;
        read_enable  = re;
        write_enable = we;
        address      = a;
        w_data       = d;
        if (a >= 16'h0100) begin
            if (re || we) eq.push_back(k);
        end else if (we) begin
            mdl[a[7:0]] = d;
        end else if (re) begin
            e.cyc  = k + 1;
            e.data = mdl[a[7:0]];
            vq.push_back(e);
        end
        @(negedge clk);
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        w_data       = '0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mv = (vq.size() > 0) && (vq[0].cyc == cyc);
            chk("r_valid", {31'd0, r_valid}, {31'd0, mv});
            if (mv) begin
                chk("r_data", {8'd0, r_data}, {8'd0, vq[0].data});
                vq.delete(0);
            end else begin
                chk("r_data_zero", {8'd0, r_data}, 32'd0);
            end
            me = (eq.size() > 0) && (eq[0] == cyc);
            chk("addr_err", {31'd0, addr_err}, {31'd0, me});
            if (me) eq.delete(0);
        end
    end

    initial begin
        rst          = 1'b1;
        address      = '0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        w_data       = '0;
        clear        = 1'b0;
        idle(3);
        chk("rst_r_data", {8'd0, r_data}, 32'd0);
        chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef PIXEL_SRAM_RESP_STATS_EN
        chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
`endif
        rst = 1'b0;
        idle(1);

        px = '{r: 8'hA1, g: 8'hB2, b: 8'hC3};
        step(1'b0, 1'b1, 16'd5, px);
        step(1'b0, 1'b1, 16'd6, 24'h000001);
        step(1'b1, 1'b0, 16'd5, 24'h0);
        step(1'b1, 1'b0, 16'd6, 24'h0);
        idle(4);

        step(1'b0, 1'b1, 16'd9, 24'h123456);
        step(1'b1, 1'b0, 16'd9, 24'h0);
        idle(4);

        step(1'b0, 1'b1, 16'd0, 24'h445566);
        step(1'b1, 1'b0, 16'h0100, 24'h0);
        step(1'b0, 1'b1, 16'h0100, 24'hDEAD11);
        step(1'b1, 1'b0, 16'hFFFF, 24'h0);
        step(1'b1, 1'b0, 16'd0, 24'h0);
        step(1'b0, 1'b1, 16'd255, 24'hABCDEF);
        step(1'b1, 1'b0, 16'd255, 24'h0);
        idle(4);

        step(1'b1, 1'b1, 16'd3, 24'h0F0F0F);
        idle(3);
        step(1'b1, 1'b0, 16'd3, 24'h0);
        idle(4);
        chk("queue_drained_1", vq.size(), 32'd0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            read_enable  = n[0];
            write_enable = ~n[0];
            address      = (n % 3 == 0) ? 16'h0200 : 16'd128;
            w_data       = 24'h777777;
            @(negedge clk);
        end
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        chk("busy_len", n, 32'd256);
        for (int i = 0; i < 256; i++) mdl[i] = '0;
        step(1'b1, 1'b0, 16'd0, 24'h0);
        step(1'b1, 1'b0, 16'd128, 24'h0);
        step(1'b1, 1'b0, 16'd255, 24'h0);
        step(1'b1, 1'b0, 16'd3, 24'h0);
        idle(4);

        step(1'b0, 1'b1, 16'd20, 24'h5A5A5A);
        read_enable = 1'b1;
        address     = 16'd20;
        @(negedge clk);
        address = 16'd21;
        @(posedge clk);
        #1;
        chk("inflight_valid", {31'd0, r_valid}, 32'd1);
        rst         = 1'b1;
        read_enable = 1'b0;
        address     = '0;
        #1;
        chk("rstrd_r_valid", {31'd0, r_valid}, 32'd0);
        chk("rstrd_r_data", {8'd0, r_data}, 32'd0);
        chk("rstrd_addr_err", {31'd0, addr_err}, 32'd0);
`ifdef PIXEL_SRAM_RESP_STATS_EN
        chk("rstrd_rd_count", {16'd0, rd_count}, 32'd0);
        chk("rstrd_wr_count", {16'd0, wr_count}, 32'd0);
        chk("rstrd_err_count", {16'd0, err_count}, 32'd0);
`endif
        vq.delete();
        eq.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(6);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle(40);
        chk("busy_mid_clear", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstclr_busy", {31'd0, busy}, 32'd0);
        chk("rstclr_r_valid", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("busy_after_rst", {31'd0, busy}, 32'd0);

        step(1'b0, 1'b1, 16'd77, 24'h13579B);
        step(1'b1, 1'b0, 16'd77, 24'h0);
        idle(4);
        chk("queue_drained_2", vq.size(), 32'd0);
        chk("err_queue_drained", eq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
